// File: rtl/serial2tcp_tx_arbiter.sv
// Round-robin, burst-locked arbiter sharing the serial2tcp sink byte stream among N_REQ requesters.
// Define SERIAL2TCP_ARB_TAG_EN to prefix every burst with a tag byte {4'hA, grant_id}.
module serial2tcp_tx_arbiter #(
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 16,
  localparam int IDW      = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int CW       = $clog2(MAX_BURST + 1)
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [8*N_REQ-1:0] req_data,
  output logic               sink_valid,
  input  logic               sink_ready,
  output logic [7:0]         sink_data,
  output logic               grant_valid,
  output logic [IDW-1:0]     grant_id
);

`ifdef SERIAL2TCP_ARB_TAG_EN
  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_TAG} state_t;
`else
  typedef enum logic [0:0] {S_IDLE, S_GRANT} state_t;
`endif

  state_t         state, state_nxt;
  logic [IDW-1:0] grant_id_nxt;
  logic [CW-1:0]  burst_cnt, burst_cnt_nxt;
  logic           load_en;
  logic           load;
  logic [7:0]     load_byte;
  logic           cur_valid;
  logic           pick_found;
  logic [IDW-1:0] pick_id;
  logic [IDW-1:0] scan_id;
  logic [7:0]     req_byte [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign req_byte[g] = req_data[8*g +: 8];
  end

  assign load_en     = !sink_valid || sink_ready;
  assign cur_valid   = req_valid[grant_id];
  assign grant_valid = (state != S_IDLE);

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = grant_id;
    scan_id    = grant_id;
    for (int k = 0; k < N_REQ; k++) begin
      scan_id = (scan_id == IDW'(N_REQ - 1)) ? '0 : scan_id + 1'b1;
      if (!pick_found && req_valid[scan_id]) begin
        pick_found = 1'b1;
        pick_id    = scan_id;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    grant_id_nxt  = grant_id;
    burst_cnt_nxt = burst_cnt;
    req_ready     = '0;
    load          = 1'b0;
    load_byte     = req_byte[grant_id];
    case (state)
      S_IDLE: begin
        if (pick_found) begin
          grant_id_nxt  = pick_id;
          burst_cnt_nxt = '0;
`ifdef SERIAL2TCP_ARB_TAG_EN
          state_nxt     = S_TAG;
`else
          state_nxt     = S_GRANT;
`endif
        end
      end
`ifdef SERIAL2TCP_ARB_TAG_EN
      S_TAG: begin
        load_byte = {4'hA, 4'(grant_id)};
        if (load_en) begin
          load      = 1'b1;
          state_nxt = S_GRANT;
        end
      end
`endif
      S_GRANT: begin
        req_ready[grant_id] = load_en;
        if (cur_valid && load_en) begin
          load          = 1'b1;
          burst_cnt_nxt = burst_cnt + 1'b1;
          if (burst_cnt_nxt == CW'(MAX_BURST)) state_nxt = S_IDLE;
        end
        // Losing valid ends the burst even while the sink is stalled.
        if (!cur_valid) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= S_IDLE;
      grant_id  <= IDW'(N_REQ - 1);
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      grant_id  <= grant_id_nxt;
      burst_cnt <= burst_cnt_nxt;
    end
  end

  // One-entry output stage: data only moves when the slot is empty or draining.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sink_valid <= 1'b0;
      sink_data  <= '0;
    end else if (load) begin
      sink_valid <= 1'b1;
      sink_data  <= load_byte;
    end else if (sink_ready) begin
      sink_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial2tcp_tx_arbiter.sv
// Scoreboard bench for serial2tcp_tx_arbiter (N_REQ=4, MAX_BURST=4); honours SERIAL2TCP_ARB_TAG_EN.
module tb_serial2tcp_tx_arbiter;
  localparam int N  = 4;
  localparam int MB = 4;

  logic           clk;
  logic           sys_rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [8*N-1:0] req_data;
  logic           sink_valid;
  logic           sink_ready;
  logic [7:0]     sink_data;
  logic           grant_valid;
  logic [1:0]     grant_id;

  serial2tcp_tx_arbiter #(.N_REQ(N), .MAX_BURST(MB)) dut (
    .sys_clk(clk), .sys_rst_n(sys_rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .sink_valid(sink_valid), .sink_ready(sink_ready), .sink_data(sink_data),
    .grant_valid(grant_valid), .grant_id(grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] rq [N][$];
  logic [7:0] sb [$];
  int         glog_id [$];
  int         glog_gap [$];
  logic       bp_mode = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic exp_tag(input int id);
`ifdef SERIAL2TCP_ARB_TAG_EN
    sb.push_back(8'hA0 | 8'(id));
`else
    if (id < 0) $display("bad requester index %0d", id);
`endif
  endtask

  task automatic send(input int id, input logic [7:0] b);
    rq[id].push_back(b);
  endtask

  // Requester models and sink_ready: drive on negedge, retire handshakes just before posedge.
  initial begin
    req_valid  = '0;
    req_data   = '0;
    sink_ready = 1'b1;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        req_valid[i]       = (rq[i].size() > 0);
        req_data[i*8 +: 8] = (rq[i].size() > 0) ? rq[i][0] : 8'h00;
      end
      sink_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      #4;
      for (int i = 0; i < N; i++)
        if (sys_rst_n && req_valid[i] && req_ready[i] && rq[i].size() > 0) void'(rq[i].pop_front());
    end
  end

  // Monitor: compares every accepted sink byte and checks stall stability.
  initial begin
    logic       held = 1'b0;
    logic [7:0] held_data = 8'h00;
    forever begin
      @(negedge clk);
      #4;
      if (!sys_rst_n) begin
        held = 1'b0;
      end else begin
        if (held) begin
          chk("stall_valid", sink_valid, 1);
          chk("stall_data", sink_data, held_data);
        end
        if (sink_valid && sink_ready) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sink_unexpected: got 0x%0h, expected no byte", sink_data);
          end else begin
            chk("sink_byte", sink_data, sb.pop_front());
          end
        end
        held      = sink_valid && !sink_ready;
        held_data = sink_data;
      end
    end
  end

  // Grant logger: records each new grant and the idle cycles preceding it.
  initial begin
    int   gap = 0;
    logic gv_q = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (grant_valid && !gv_q) begin
        glog_id.push_back(int'(grant_id));
        glog_gap.push_back(gap);
      end
      gap  = grant_valid ? 0 : gap + 1;
      gv_q = grant_valid;
    end
  end

  task automatic chk_glog(input string name, input int n, input logic [31:0] ids);
    chk({name, "_ngrants"}, glog_id.size(), n);
    for (int k = 0; k < n && k < glog_id.size(); k++) begin
      chk({name, "_gid"}, glog_id[k], (ids >> (4 * k)) & 32'hF);
      if (k > 0) chk({name, "_gap"}, glog_gap[k], 1);
    end
  endtask

  task automatic drain(input string name, input int budget);
    int c = 0;
    while ((sb.size() > 0 || rq[0].size() > 0 || rq[1].size() > 0 ||
            rq[2].size() > 0 || rq[3].size() > 0) && c < budget) begin
      @(posedge clk);
      c++;
    end
    chk({name, "_drained"}, sb.size(), 0);
    repeat (3) @(posedge clk);
    #1;
    chk({name, "_idle"}, grant_valid, 0);
    chk({name, "_sink_empty"}, sink_valid, 0);
  endtask

  initial begin
    int c;
    sys_rst_n = 1'b0;
    #12;
    chk("rst_sink_valid", sink_valid, 0);
    chk("rst_sink_data", sink_data, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_grant_valid", grant_valid, 0);
    chk("rst_grant_id", grant_id, N - 1);
    @(posedge clk);
    #2;
    sys_rst_n = 1'b1;

    // Single requester: latency and ordering, burst split at MAX_BURST
    @(posedge clk);
    #1;
    glog_id.delete();
    glog_gap.delete();
    for (int j = 1; j <= 5; j++) begin
      send(0, 8'(j));
      if (j == 1 || j == 5) exp_tag(0);
      sb.push_back(8'(j));
    end
    @(posedge clk);
    #1;
    chk("t1_grant_valid", grant_valid, 1);
    chk("t1_grant_id", grant_id, 0);
    chk("t1_sink_not_yet", sink_valid, 0);
    @(posedge clk);
    #1;
    chk("t1_sink_valid", sink_valid, 1);
`ifdef SERIAL2TCP_ARB_TAG_EN
    chk("t1_tag", sink_data, 8'hA0);
    @(posedge clk);
    #1;
`endif
    chk("t1_first_byte", sink_data, 8'h01);
    drain("t1", 200);
    chk_glog("t1", 2, 32'h00);

    // Burst limit: req 1 (10 bytes) against req 2 (4 bytes)
    @(posedge clk);
    #1;
    glog_id.delete();
    glog_gap.delete();
    for (int j = 0; j < 10; j++) send(1, 8'h10 + 8'(j));
    for (int j = 0; j < 4; j++) send(2, 8'h20 + 8'(j));
    exp_tag(1); for (int j = 0; j < 4; j++) sb.push_back(8'h10 + 8'(j));
    exp_tag(2); for (int j = 0; j < 4; j++) sb.push_back(8'h20 + 8'(j));
    exp_tag(1); for (int j = 4; j < 8; j++) sb.push_back(8'h10 + 8'(j));
    exp_tag(1); for (int j = 8; j < 10; j++) sb.push_back(8'h10 + 8'(j));
    drain("t2", 300);
    chk_glog("t2", 4, 32'h1121);

    // Round robin with all four requesters continuously valid (pointer at 1)
    @(posedge clk);
    #1;
    glog_id.delete();
    glog_gap.delete();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < 8; j++) send(i, 8'h80 + 8'(16 * i + j));
    for (int r = 0; r < 2; r++) begin
      for (int s = 0; s < N; s++) begin
        int id;
        id = (2 + s) % N;
        exp_tag(id);
        for (int j = 0; j < 4; j++) sb.push_back(8'h80 + 8'(16 * id + 4 * r + j));
      end
    end
    drain("t3", 400);
    chk_glog("t3", 8, 32'h10321032);

    // Backpressure: random sink_ready over a 32-byte stream from req 3
    @(posedge clk);
    #1;
    glog_id.delete();
    glog_gap.delete();
    bp_mode = 1'b1;
    for (int j = 0; j < 32; j++) begin
      send(3, 8'hC0 + 8'(j));
      if (j % 4 == 0) exp_tag(3);
      sb.push_back(8'hC0 + 8'(j));
    end
    drain("t4", 2000);
    bp_mode = 1'b0;
    chk_glog("t4", 8, 32'h33333333);

    // Reset in the middle of a burst
    @(posedge clk);
    #1;
    for (int j = 0; j < 8; j++) send(0, 8'hE0 + 8'(j));
    exp_tag(0);
    for (int j = 0; j < 4; j++) sb.push_back(8'hE0 + 8'(j));
    c = 0;
    while (!sink_valid && c < 20) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk("t5_sink_started", sink_valid, 1);
    @(posedge clk);
    #2;
    sys_rst_n = 1'b0;
    sb.delete();
    rq[0].delete();
    #1;
    chk("t5_rst_sink_valid", sink_valid, 0);
    chk("t5_rst_req_ready", req_ready, 0);
    chk("t5_rst_grant_valid", grant_valid, 0);
    chk("t5_rst_grant_id", grant_id, N - 1);
    @(posedge clk);
    @(posedge clk);
    #2;
    sys_rst_n = 1'b1;
    @(posedge clk);
    #1;
    glog_id.delete();
    glog_gap.delete();
    send(0, 8'h5A);
    send(3, 8'h6B);
    exp_tag(0); sb.push_back(8'h5A);
    exp_tag(3); sb.push_back(8'h6B);
    drain("t5", 200);
    chk_glog("t5", 2, 32'h30);

    // Single byte from req 2 (tagged as A2 when tags are enabled)
    @(posedge clk);
    #1;
    glog_id.delete();
    glog_gap.delete();
    send(2, 8'h55);
    exp_tag(2);
    sb.push_back(8'h55);
    drain("t6", 200);
    chk_glog("t6", 1, 32'h2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial2tcp_tx_arbiter.md
Name: serial2tcp_tx_arbiter

Overview:
- Shares the single serial2tcp sink byte stream (valid/ready/8-bit data, toward the TCP side) between N_REQ independent byte-stream requesters.
- Round-robin arbitration with burst locking: a granted requester keeps the sink until it drops valid or has sent MAX_BURST bytes.
- Output is registered (one-entry output stage) so sink_valid/sink_data are driven only from flops.
- Sits between the SoC-side byte producers and the serial2tcp sink port of the loopback/bridge.

Parameters:
- N_REQ, 4, number of requester streams (2..16).
- MAX_BURST, 16, maximum bytes per grant before forced re-arbitration (1..255).

Ports:
- sys_clk  in  1  system clock, all logic on rising edge.
- sys_rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  per-requester byte valid.
- req_ready  out  N_REQ  per-requester byte accept.
- req_data  in  8*N_REQ  per-requester byte; requester i on bits [8i+7:8i].
- sink_valid  out  1  byte valid toward serial2tcp sink.
- sink_ready  in  1  serial2tcp sink accept.
- sink_data  out  8  byte toward serial2tcp sink.
- grant_valid  out  1  high while in a grant state (GRANT or TAG).
- grant_id  out  IDW  current/last granted index; IDW = max(1, clog2(N_REQ)).

Behaviour:
- Reset (async assert, sync-release use): state=IDLE, sink_valid=0, sink_data=0, req_ready=0, grant_valid=0, grant_id=N_REQ-1 (so first search starts at 0), burst count=0.
- Output stage: load_en = !sink_valid || sink_ready. On load, sink_valid<=1 and sink_data<=selected byte; else if sink_ready, sink_valid<=0. Never changes sink_data while sink_valid && !sink_ready.
- req_ready[i] = (state==GRANT) && (i==grant_id) && load_en; combinational. All other bits 0. Transfer = req_valid[i] && req_ready[i].
- IDLE: if any req_valid, pick the first set index searching grant_id+1, +2, ... modulo N_REQ. Register grant_id, clear count, go to GRANT (TAG when feature enabled). No request: stay IDLE.
- GRANT: each transfer increments count (width clog2(MAX_BURST+1)).
- GRANT exit: leave to IDLE when a transfer makes count==MAX_BURST, or when req_valid[grant_id]==0 (checked every cycle, regardless of load_en).
- GRANT with load_en=0: no transfer and no count change.
- Latency: req_valid rising while IDLE at edge k → grant at edge k; first byte accepted at edge k+1; sink_valid high after k+1 (2 cycles). Throughput is 1 byte/cycle when sink_ready is held high.
- Re-arbitration gap: one IDLE cycle between bursts. The same requester may win again only if no other requester is valid.
- Simultaneous requests: the lowest index at or after grant_id+1 wins (modulo N_REQ). No starvation: the worst-case wait is (N_REQ-1) bursts.
- Requester valid deasserted mid-burst: burst ends and the byte already in the output stage is still delivered.
- sink_ready low for any duration: holds all state, no bytes dropped or duplicated.
- grant_id is held in IDLE (round-robin pointer).

Optional Feature:
- Macro SERIAL2TCP_ARB_TAG_EN.
- Defined: adds state TAG entered from IDLE. TAG loads the tag byte {4'hA, grant_id zero-extended to 4 bits} into the output stage when load_en, then goes to GRANT. The tag does not count toward MAX_BURST. req_ready=0 in TAG. First payload byte latency becomes 3 cycles.
- Not defined: no TAG state, no tag bytes; the sink sees raw payload only.

Test Plan:
- Single requester: req 0 sends 0x01..0x05, sink_ready=1 → sink sees 01..05 in order; sink_valid first high 2 cycles after req_valid; grant_id=0; back to IDLE after valid drops.
- Burst limit (MAX_BURST=4): req 1 holds valid with 10 bytes, req 2 also valid → sink sees 4 bytes from req 1, 4 bytes from req 2, then the remaining bytes of req 1; one idle cycle between bursts.
- Round-robin fairness: all 4 requesters continuously valid → grant_id sequence 0,1,2,3,0,...; every byte appears exactly once.
- Backpressure: toggle sink_ready randomly (50%) during a 32-byte stream → sink_data stable while stalled; output matches the input order with no loss or duplication.
- Reset mid-burst: drop sys_rst_n with sink_valid=1 → sink_valid, req_ready and grant_valid go 0 immediately (asynchronously); after release, the next grant starts from index 0.
- With SERIAL2TCP_ARB_TAG_EN: req 2 sends 0x55 → sink sees 0xA2 then 0x55.
